// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master Wishbone arbiter, alternating on ties; BUS_ARBITER_TIMEOUT_EN adds a slave watchdog.
// One-cycle grant latency; the non-owner stalls with ack/err low until the owner drops cyc.
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    state_t     state_q;
    logic       last_q;     // 1: m1 owned the bus most recently
    logic [1:0] grant_q;
    logic       owner_stb;
    logic       to_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                        state_q <= GRANT0;
                        grant_q <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state_q <= GRANT1;
                        grant_q <= 2'b10;
                    end
                end
                GRANT0: begin
                    if (!m0_cyc_i) begin
                        last_q <= 1'b0;
                        if (m1_cyc_i) begin
                            state_q <= GRANT1;
                            grant_q <= 2'b10;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= 2'b00;
                        end
                    end
                end
                GRANT1: begin
                    if (!m1_cyc_i) begin
                        last_q <= 1'b1;
                        if (m0_cyc_i) begin
                            state_q <= GRANT0;
                            grant_q <= 2'b01;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= 2'b00;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign owner_stb = ((state_q == GRANT0) && m0_stb_i) || ((state_q == GRANT1) && m1_stb_i);

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign to_hit = (state_q != IDLE) && (cnt_q == TO_LIM);

    always_comb begin
        cnt_d = 16'd0;
        if (!to_hit && owner_stb && !s_ack_i && !s_err_i)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            cnt_q <= 16'd0;
        else
            cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TO_LIM;
    assign to_hit         = 1'b0;
`endif

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = 32'd0;
        s_dat_o = 32'd0;
        s_sel_o = 4'd0;
        case (state_q)
            GRANT0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i && !to_hit;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
            end
            GRANT1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i && !to_hit;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
            end
            default: ;
        endcase
    end

    // Responses are gated by reset as well as ownership so nothing leaks during reset.
    assign m0_ack_o = !reset && (state_q == GRANT0) && s_ack_i;
    assign m1_ack_o = !reset && (state_q == GRANT1) && s_ack_i;
    assign m0_err_o = !reset && (state_q == GRANT0) && (s_err_i || to_hit);
    assign m1_err_o = !reset && (state_q == GRANT1) && (s_err_i || to_hit);
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grant latency, tie alternation, block hold, reset abort, watchdog.
module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i;
    logic [1:0]  grant_o;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    bit wd_en;

    always #5 clock = ~clock;

    bus_arbiter #(.TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic look();
        #1;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic       exp_err;
`ifdef BUS_ARBITER_TIMEOUT_EN
        wd_en = 1'b1;
`else
        wd_en = 1'b0;
`endif
        reset = 1'b1;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = 0; m0_dat_i = 0; m0_sel_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = 0; m1_dat_i = 0; m1_sel_i = 0;
        s_dat_i = 32'h0; s_ack_i = 1'b1; s_err_i = 1'b0;
        tick(); tick();
        look();
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_scyc", 32'(s_cyc_o), 32'h0);
        chk("rst_m0ack", 32'(m0_ack_o), 32'h0);
        chk("rst_m1ack", 32'(m1_ack_o), 32'h0);
        s_ack_i = 1'b0;
        reset   = 1'b0;

        // Single m0 read, slave answers on the third owned cycle.
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0010; m0_sel_i = 4'hF;
        look();
        chk("rd_scyc_pre", 32'(s_cyc_o), 32'h0);
        chk("rd_grant_pre", 32'(grant_o), 32'h0);
        tick(); look();
        chk("rd_scyc", 32'(s_cyc_o), 32'h1);
        chk("rd_sadr", s_adr_o, 32'h0000_0010);
        chk("rd_grant", 32'(grant_o), 32'h1);
        chk("rd_ack_wait", 32'(m0_ack_o), 32'h0);
        tick();
        tick();
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        look();
        chk("rd_ack", 32'(m0_ack_o), 32'h1);
        chk("rd_dat", m0_dat_o, 32'hDEAD_BEEF);
        chk("rd_m1dat", m1_dat_o, 32'hDEAD_BEEF);
        chk("rd_m1ack", 32'(m1_ack_o), 32'h0);
        tick();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        tick(); look();
        chk("rd_idle", 32'(grant_o), 32'h0);
        chk("rd_idle_sadr", s_adr_o, 32'h0);

        // Simultaneous request right after reset: m0 first, m1 without an idle gap.
        reset = 1;
        tick();
        reset = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h200; m1_we_i = 1; m1_dat_i = 32'h1234_5678;
        tick();
        s_ack_i = 1;
        look();
        chk("tie_grant0", 32'(grant_o), 32'h1);
        chk("tie_sadr0", s_adr_o, 32'h100);
        chk("tie_m0ack", 32'(m0_ack_o), 32'h1);
        chk("tie_m1ack_blk", 32'(m1_ack_o), 32'h0);
        tick();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        look();
        chk("tie_hold0", 32'(grant_o), 32'h1);
        tick();
        s_ack_i = 1;
        look();
        chk("tie_grant1", 32'(grant_o), 32'h2);
        chk("tie_sadr1", s_adr_o, 32'h200);
        chk("tie_swe1", 32'(s_we_o), 32'h1);
        chk("tie_sdat1", s_dat_o, 32'h1234_5678);
        chk("tie_m1ack", 32'(m1_ack_o), 32'h1);
        chk("tie_m0ack_blk", 32'(m0_ack_o), 32'h0);
        tick();
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; s_ack_i = 0;
        tick();

        // Repeated ties alternate owners, starting with m0 since m1 owned last.
        for (int r = 0; r < 4; r++) begin
            exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
            m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
            tick();
            s_ack_i = 1;
            look();
            chk("alt_grant", 32'(grant_o), 32'(exp_g));
            chk("alt_m0ack", 32'(m0_ack_o), 32'(exp_g[0]));
            chk("alt_m1ack", 32'(m1_ack_o), 32'(exp_g[1]));
            tick();
            m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
            tick();
        end

        // m1 block transfer with strobe gaps keeps the bus while m0 waits.
        m1_cyc_i = 1; m1_adr_i = 32'h300;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h400;
        for (int b = 0; b < 4; b++) begin
            m1_stb_i = 1; s_ack_i = 1;
            look();
            chk("blk_grant", 32'(grant_o), 32'h2);
            chk("blk_sadr", s_adr_o, 32'h300);
            chk("blk_m1ack", 32'(m1_ack_o), 32'h1);
            chk("blk_m0ack", 32'(m0_ack_o), 32'h0);
            tick();
            m1_stb_i = 0; s_ack_i = 0;
            look();
            chk("blk_gap_grant", 32'(grant_o), 32'h2);
            chk("blk_gap_sstb", 32'(s_stb_o), 32'h0);
            tick();
        end
        m1_cyc_i = 0;
        look();
        chk("blk_drop_grant", 32'(grant_o), 32'h2);
        tick(); look();
        chk("blk_m0_grant", 32'(grant_o), 32'h1);
        chk("blk_m0_sadr", s_adr_o, 32'h400);
        m0_cyc_i = 0; m0_stb_i = 0;
        tick(); tick();

        // Reset while m1 waits for its ack.
        m1_cyc_i = 1; m1_stb_i = 1;
        tick(); look();
        chk("rab_scyc", 32'(s_cyc_o), 32'h1);
        chk("rab_grant", 32'(grant_o), 32'h2);
        reset = 1; s_ack_i = 1;
        look();
        chk("rab_m1ack_in_rst", 32'(m1_ack_o), 32'h0);
        tick(); look();
        chk("rab_scyc_after", 32'(s_cyc_o), 32'h0);
        chk("rab_sstb_after", 32'(s_stb_o), 32'h0);
        chk("rab_grant_after", 32'(grant_o), 32'h0);
        chk("rab_m1ack_after", 32'(m1_ack_o), 32'h0);
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        tick();
        reset = 0;
        tick();

        // Silent slave: with the watchdog err pulses on the ninth owned cycle.
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h500;
        tick();
        for (int k = 1; k <= 12; k++) begin
            exp_err = wd_en && (k == 9);
            look();
            chk("wd_err", 32'(m0_err_o), 32'(exp_err));
            chk("wd_sstb", 32'(s_stb_o), 32'(!exp_err));
            chk("wd_m1err", 32'(m1_err_o), 32'h0);
            tick();
        end
        m0_cyc_i = 0; m0_stb_i = 0;
        tick(); look();
        chk("wd_idle", 32'(grant_o), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the slave-response watchdog limit in cycles (1..65535); used only with BUS_ARBITER_TIMEOUT_EN.
REQ-002 clock  in  1  bus clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (instruction bus) Wishbone cycle, strobe and write-enable.
REQ-005 m0_adr_i  in  32; m0_dat_i  in  32; m0_sel_i  in  4  master 0 address, write data and byte selects.
REQ-006 m0_dat_o  out  32; m0_ack_o, m0_err_o  out  1 each  master 0 read data, acknowledge and error.
REQ-007 m1_* SHALL be identical to m0_* and carry master 1 (data bus).
REQ-008 s_cyc_o, s_stb_o, s_we_o  out  1; s_adr_o, s_dat_o  out  32; s_sel_o  out  4  shared slave request.
REQ-009 s_dat_i  in  32; s_ack_i, s_err_i  in  1  shared slave response.
REQ-010 grant_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle.

Function
REQ-011 FSM states SHALL be IDLE, GRANT0, GRANT1; state and a last-owner bit SHALL be registered.
REQ-012 IDLE: m0_cyc_i only -> GRANT0; m1_cyc_i only -> GRANT1; both -> grant the master that is not last-owner; neither -> stay IDLE.
REQ-013 GRANTn SHALL persist while mn_cyc_i is high, regardless of mn_stb_i, so block cycles are never split.
REQ-014 GRANTn with mn_cyc_i low: other master requesting -> GRANT of other master next cycle, else -> IDLE; last-owner SHALL be set to n.
REQ-015 Grant latency SHALL be exactly one cycle from cyc assertion in IDLE to s_cyc_o assertion.
REQ-016 In GRANTn, s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o SHALL combinationally equal the mn_* inputs.
REQ-017 In IDLE, all s_* outputs SHALL be zero.
REQ-018 mn_ack_o = s_ack_i and mn_err_o = s_err_i only when GRANTn; otherwise 0.
REQ-019 m0_dat_o and m1_dat_o SHALL both equal s_dat_i at all times.
REQ-020 A non-owner's cyc/stb SHALL have no effect on slave outputs; it waits with ack/err held 0.
REQ-021 grant_o SHALL be decoded from the registered state (no combinational path from inputs).

Reset
REQ-022 reset SHALL force state IDLE, last-owner = m1 (so m0 wins the first tie), grant_o = 00, watchdog counter = 0.
REQ-023 reset asserted mid-transfer SHALL drop s_cyc_o/s_stb_o to 0 the following cycle regardless of slave state.
REQ-024 All m*_ack_o and m*_err_o SHALL be 0 while in reset.

Configuration
REQ-025 Macro BUS_ARBITER_TIMEOUT_EN SHALL compile in a 16-bit watchdog counter.
REQ-026 With it: counter increments each cycle the owner has stb high and s_ack_i/s_err_i low, clears otherwise; on reaching TIMEOUT the owner's err_o SHALL pulse 1 cycle, s_stb_o SHALL be forced 0 that cycle, and the counter SHALL clear.
REQ-027 Without it: no counter is present; err_o follows REQ-018 only and a non-responding slave stalls the owner indefinitely.

Verification
REQ-028 Reset, then m0 cyc/stb read adr 0x0000_0010, slave acks after 2 cycles with 0xDEADBEEF -> s_cyc_o rises 1 cycle after m0_cyc_i, m0_ack_o with m0_dat_o = 0xDEADBEEF, grant_o = 01.
REQ-029 m0 and m1 assert cyc in the same cycle from IDLE after reset -> GRANT0 first; m1 granted the cycle after m0 drops cyc, with no IDLE gap.
REQ-030 Repeated simultaneous requests, each a single transfer -> grants alternate m0, m1, m0, m1; m1_ack_o never asserts during GRANT0.
REQ-031 m1 holds cyc over 4-beat block with stb gaps while m0 requests -> m1 keeps grant for all 4 beats; m0 granted only after m1 drops cyc.
REQ-032 reset asserted while GRANT1 awaits ack -> next cycle s_cyc_o = 0, grant_o = 00, m1_ack_o = 0.
REQ-033 With BUS_ARBITER_TIMEOUT_EN, TIMEOUT = 8, slave never acks -> m0_err_o pulses after 8 stalled cycles; without the macro, no err, cycle stalls.
